dram_cmd_responder: RTL and testbench
=====================================

Name: dram_cmd_responder

Overview:
- Synthesizable, cycle-accurate DRAM device model. It is the responder on the RAS/CAS command pins driven by the DRAM-side AXI slave wrapper.
- Decodes activate, read, write and precharge commands, holds one open row and performs byte-masked writes.
- Returns read data after a fixed CAS latency with a one-cycle valid pulse.
- Checks the tRCD, tRP and protocol ordering rules and reports the first violation.

Parameters:
- ROW_BITS, 11, row address width; taken from DRAM_A_i[ROW_BITS-1:0] on ACT.
- COL_BITS, 10, column address width; taken from DRAM_A_i[COL_BITS-1:0] on READ/WRITE.
- DATA_BITS, 32, word width; byte lanes = DATA_BITS/8.
- CAS_LAT, 5, cycles from READ command edge to DRAM_valid_o high; legal range 1..8.
- T_RCD, 5, minimum cycles from ACT to READ/WRITE.
- T_RP, 5, minimum cycles from PRE to the next ACT.

Ports:
- clk  in  1  clock; all sampling on the rising edge
- rst  in  1  asynchronous, active-high reset
- DRAM_CSn_i  in  1  chip select, active low; command ignored when high
- DRAM_RASn_i  in  1  row strobe, active low
- DRAM_CASn_i  in  1  column strobe, active low
- DRAM_WEn_i  in  DATA_BITS/8  per-byte write enable, active low
- DRAM_A_i  in  11  row/column address
- DRAM_D_i  in  DATA_BITS  write data
- DRAM_Q_o  out  DATA_BITS  read data; holds its last value between reads
- DRAM_valid_o  out  1  one-cycle pulse, DRAM_Q_o valid
- err_o  out  1  sticky; a violation has occurred since reset
- err_code_o  out  3  sticky code of the first violation

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
  - On reset: DRAM_Q_o=0, DRAM_valid_o=0, err_o=0, err_code_o=0, row_open=0, read pipeline flushed.
  - The tRCD and tRP counters reset to their saturated value, so the first ACT/CAS after reset is legal.
  - Memory contents are not reset. Reset mid-read drops every pending valid.
- Command decode (sampled each edge with CSn=0; no command when CSn=1):
  - ACT: RASn=0, CASn=1, WEn all 1.
  - PRE: RASn=0, CASn=1, WEn all 0.
  - READ: RASn=1, CASn=0, WEn all 1.
  - WRITE: RASn=1, CASn=0, any WEn bit 0.
  - NOP: RASn=1, CASn=1.
  - Any other RAS/WEn combination is treated as NOP.
- State: IDLE (no open row) and ACTIVE (row open, open_row register).
  - ACT in IDLE opens a row: IDLE -> ACTIVE.
  - PRE in ACTIVE closes it: ACTIVE -> IDLE.
  - PRE in IDLE is a legal no-op.
- Counters:
  - act_cnt counts cycles since the last accepted ACT, saturating at T_RCD.
  - pre_cnt counts cycles since the last PRE, saturating at T_RP.
  - A command at edge t+N after the ACT/PRE at edge t sees a distance of N.
- READ:
  - Array word {open_row, col} is read at the command edge into a CAS_LAT-deep shift pipeline.
  - The data appears on DRAM_Q_o with DRAM_valid_o=1 exactly CAS_LAT edges later, for one cycle.
  - One READ per cycle is supported; back-to-back READs give back-to-back valids.
- WRITE:
  - At the command edge, byte lane i is written from DRAM_D_i[8i+7:8i] where DRAM_WEn_i[i]=0.
  - No response output.
  - A READ of the same address on a later edge returns the new data.
- Violations: the offending command is ignored (state and array unchanged). err_o and err_code_o latch on the first violation only; later violations do not overwrite. Codes:
  - 1: READ/WRITE in IDLE.
  - 2: ACT in ACTIVE.
  - 3: READ/WRITE with distance < T_RCD.
  - 4: ACT with distance < T_RP.
  - 5: RASn=0 and CASn=0 together (illegal).
- Precedence: when several rules are broken on one edge, the lowest code is reported.
- Reads already in the pipeline still complete after a PRE, a violation or a new ACT.

Test Plan:
- Reset, then ACT row 0x12 at t0, WRITE col 0x34 at t0+5 with WEn=0000 and D=0xDEADBEEF, READ col 0x34 at t0+10 -> valid at t0+15 with Q=0xDEADBEEF; err_o=0.
- Same address, WRITE with WEn=1110 and D=0x000000AA, then READ -> Q=0xDEADBEAA; then WRITE with WEn=0011 and D=0x5555xxxx, then READ -> Q=0x5555BEAA.
- READ at ACT+4 -> no valid pulse, err_o=1, err_code_o=3; a READ at ACT+5 then succeeds and err_code_o stays 3.
- Four READs of cols 0..3 on consecutive cycles -> four consecutive valid pulses in order; PRE issued the cycle after the last READ does not suppress them.
- PRE at t, then ACT at t+4 -> err_code_o=4 and state stays IDLE; ACT at t+5 is accepted, and a READ 5 cycles later returns data.
- READ pending with 2 cycles of latency left, then assert rst -> DRAM_valid_o never pulses and DRAM_Q_o=0; array data written before reset is readable after re-ACT.

Source files
------------

// File: rtl/dram_cmd_responder.sv
// Cycle-accurate DRAM device model answering RAS/CAS commands: one open
// row, byte-masked writes, fixed-latency reads and sticky timing/protocol
// violation reporting.
module dram_cmd_responder #(
  parameter int ROW_BITS  = 11,
  parameter int COL_BITS  = 10,
  parameter int DATA_BITS = 32,
  parameter int CAS_LAT   = 5,
  parameter int T_RCD     = 5,
  parameter int T_RP      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   DRAM_CSn_i,
  input  logic                   DRAM_RASn_i,
  input  logic                   DRAM_CASn_i,
  input  logic [DATA_BITS/8-1:0] DRAM_WEn_i,
  input  logic [10:0]            DRAM_A_i,
  input  logic [DATA_BITS-1:0]   DRAM_D_i,
  output logic [DATA_BITS-1:0]   DRAM_Q_o,
  output logic                   DRAM_valid_o,
  output logic                   err_o,
  output logic [2:0]             err_code_o
);

  localparam int LANES = DATA_BITS / 8;
  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int RCD_W = $clog2(T_RCD + 1) < 1 ? 1 : $clog2(T_RCD + 1);
  localparam int RP_W  = $clog2(T_RP + 1) < 1 ? 1 : $clog2(T_RP + 1);
  localparam logic [RCD_W-1:0] RCD_SAT = RCD_W'(T_RCD);
  localparam logic [RP_W-1:0]  RP_SAT  = RP_W'(T_RP);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_IDLE_CAS   = 3'd1,
    ERR_ACT_ACTIVE = 3'd2,
    ERR_TRCD       = 3'd3,
    ERR_TRP        = 3'd4,
    ERR_RAS_CAS    = 3'd5
  } err_t;

  state_t               state, state_next;
  err_t                 viol;
  logic [ROW_BITS-1:0]  open_row;
  logic [RCD_W-1:0]     act_cnt;
  logic [RP_W-1:0]      pre_cnt;
  logic                 act_ok, pre_ok, rd_ok, wr_ok;
  logic                 cmd_act, cmd_pre, cmd_rd, cmd_wr, cmd_bad;
  logic [AW-1:0]        cas_addr;

  logic [DATA_BITS-1:0] mem [0:(1<<AW)-1];
  logic [CAS_LAT-1:0]   pipe_v;
  logic [DATA_BITS-1:0] pipe_d [CAS_LAT];

  // Raw command decode; undefined RAS/WEn combinations fall through as NOP.
  always_comb begin
    cmd_act  = !DRAM_CSn_i && !DRAM_RASn_i &&  DRAM_CASn_i &&  (&DRAM_WEn_i);
    cmd_pre  = !DRAM_CSn_i && !DRAM_RASn_i &&  DRAM_CASn_i && ~(|DRAM_WEn_i);
    cmd_rd   = !DRAM_CSn_i &&  DRAM_RASn_i && !DRAM_CASn_i &&  (&DRAM_WEn_i);
    cmd_wr   = !DRAM_CSn_i &&  DRAM_RASn_i && !DRAM_CASn_i && ~(&DRAM_WEn_i);
    cmd_bad  = !DRAM_CSn_i && !DRAM_RASn_i && !DRAM_CASn_i;
    cas_addr = {open_row, DRAM_A_i[COL_BITS-1:0]};
  end

  // Row state next-state and command acceptance; lowest violation code wins.
  always_comb begin
    state_next = state;
    viol       = ERR_NONE;
    act_ok     = 1'b0;
    pre_ok     = 1'b0;
    rd_ok      = 1'b0;
    wr_ok      = 1'b0;
    if (cmd_rd || cmd_wr) begin
      if (state == IDLE)          viol = ERR_IDLE_CAS;
      else if (act_cnt < RCD_SAT) viol = ERR_TRCD;
      else begin
        rd_ok = cmd_rd;
        wr_ok = cmd_wr;
      end
    end else if (cmd_act) begin
      if (state == ACTIVE)        viol = ERR_ACT_ACTIVE;
      else if (pre_cnt < RP_SAT)  viol = ERR_TRP;
      else begin
        act_ok     = 1'b1;
        state_next = ACTIVE;
      end
    end else if (cmd_pre) begin
      pre_ok     = 1'b1;
      state_next = IDLE;
    end else if (cmd_bad) begin
      viol = ERR_RAS_CAS;
    end
  end

  // Row state register and open row address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      open_row <= '0;
    end else begin
      state <= state_next;
      if (act_ok) open_row <= DRAM_A_i[ROW_BITS-1:0];
    end
  end

  // Distance counters: loading 1 on the command edge makes a command N edges
  // later see exactly N; reset to saturation so the first command is legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_cnt <= RCD_SAT;
      pre_cnt <= RP_SAT;
    end else begin
      if (act_ok)                 act_cnt <= RCD_W'(1);
      else if (act_cnt < RCD_SAT) act_cnt <= act_cnt + 1'b1;
      if (pre_ok)                 pre_cnt <= RP_W'(1);
      else if (pre_cnt < RP_SAT)  pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Byte-masked array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!DRAM_WEn_i[i]) mem[cas_addr][8*i +: 8] <= DRAM_D_i[8*i +: 8];
      end
    end
  end

  // Read pipeline: data captured at the command edge, then CAS_LAT-1 shifts
  // plus the output register give exactly CAS_LAT edges to the valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v       <= '0;
      DRAM_valid_o <= 1'b0;
      DRAM_Q_o     <= '0;
      for (int unsigned i = 0; i < CAS_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_ok;
      pipe_d[0] <= mem[cas_addr];
      for (int unsigned i = 1; i < CAS_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      DRAM_valid_o <= pipe_v[CAS_LAT-1];
      if (pipe_v[CAS_LAT-1]) DRAM_Q_o <= pipe_d[CAS_LAT-1];
    end
  end

  // Sticky first-violation report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else if (!err_o && viol != ERR_NONE) begin
      err_o      <= 1'b1;
      err_code_o <= viol;
    end
  end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed bench for dram_cmd_responder with a read-data scoreboard: issued
// reads push expected data and arrival edge, a monitor pops on each valid.
module tb_dram_cmd_responder;

  localparam int CL = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DRAM_CSn_i  = 1'b1;
  logic        DRAM_RASn_i = 1'b1;
  logic        DRAM_CASn_i = 1'b1;
  logic [3:0]  DRAM_WEn_i  = 4'hF;
  logic [10:0] DRAM_A_i    = '0;
  logic [31:0] DRAM_D_i    = '0;
  logic [31:0] DRAM_Q_o;
  logic        DRAM_valid_o;
  logic        err_o;
  logic [2:0]  err_code_o;

  typedef struct {
    logic [31:0] data;
    int unsigned edge_n;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;

  dram_cmd_responder #(
    .ROW_BITS (11),
    .COL_BITS (10),
    .DATA_BITS(32),
    .CAS_LAT  (CL),
    .T_RCD    (5),
    .T_RP     (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DRAM_CSn_i  (DRAM_CSn_i),
    .DRAM_RASn_i (DRAM_RASn_i),
    .DRAM_CASn_i (DRAM_CASn_i),
    .DRAM_WEn_i  (DRAM_WEn_i),
    .DRAM_A_i    (DRAM_A_i),
    .DRAM_D_i    (DRAM_D_i),
    .DRAM_Q_o    (DRAM_Q_o),
    .DRAM_valid_o(DRAM_valid_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp commands and responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest expected read, on time.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (DRAM_valid_o) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: Q=%h at edge %0d, no read pending", DRAM_Q_o, cyc);
      end else begin
        e = sb.pop_front();
        if (DRAM_Q_o !== e.data || cyc != e.edge_n) begin
          mismatched++;
          $display("FAIL read_data: got Q=%h at edge %0d, expected %h at edge %0d",
                   DRAM_Q_o, cyc, e.data, e.edge_n);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one command for exactly one edge, then return to NOP.
  task automatic issue(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    DRAM_CSn_i  = csn;
    DRAM_RASn_i = rasn;
    DRAM_CASn_i = casn;
    DRAM_WEn_i  = wen;
    DRAM_A_i    = a;
    DRAM_D_i    = d;
    @(posedge clk);
    #1;
    DRAM_CSn_i  = 1'b1;
    DRAM_RASn_i = 1'b1;
    DRAM_CASn_i = 1'b1;
    DRAM_WEn_i  = 4'hF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic act(input logic [10:0] row);
    issue(1'b0, 1'b0, 1'b1, 4'hF, row, '0);
  endtask

  task automatic pre();
    issue(1'b0, 1'b0, 1'b1, 4'h0, '0, '0);
  endtask

  task automatic wr(input logic [10:0] col, input logic [3:0] wen, input logic [31:0] d);
    issue(1'b0, 1'b1, 1'b0, wen, col, d);
  endtask

  task automatic rd(input logic [10:0] col, input logic [31:0] exp);
    exp_t e;
    issue(1'b0, 1'b1, 1'b0, 4'hF, col, '0);
    e.data   = exp;
    e.edge_n = cyc + CL;
    sb.push_back(e);
  endtask

  task automatic rd_nopush(input logic [10:0] col);
    issue(1'b0, 1'b1, 1'b0, 4'hF, col, '0);
  endtask

  // Run-time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wd [4];
    wd[0] = 32'h01234567;
    wd[1] = 32'h89ABCDEF;
    wd[2] = 32'hFEDCBA98;
    wd[3] = 32'h76543210;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", DRAM_Q_o, 32'h0);
    chk("reset_valid", {31'b0, DRAM_valid_o}, 32'h0);
    chk("reset_err", {31'b0, err_o}, 32'h0);
    chk("reset_code", {29'b0, err_code_o}, 32'h0);
    rst = 1'b0;

    // ACT, full write, read back.
    act(11'h012);
    idle(4);
    wr(11'h034, 4'b0000, 32'hDEADBEEF);
    idle(4);
    rd(11'h034, 32'hDEADBEEF);
    idle(CL + 1);
    chk("no_err_basic", {31'b0, err_o}, 32'h0);

    // Byte-masked writes.
    wr(11'h034, 4'b1110, 32'h000000AA);
    rd(11'h034, 32'hDEADBEAA);
    wr(11'h034, 4'b0011, 32'h55551234);
    rd(11'h034, 32'h5555BEAA);
    idle(CL + 1);

    // tRCD violation at ACT+4, legal READ at ACT+5.
    pre();
    idle(4);
    act(11'h012);
    idle(3);
    rd_nopush(11'h034);
    rd(11'h034, 32'h5555BEAA);
    chk("trcd_err", {31'b0, err_o}, 32'h1);
    chk("trcd_code", {29'b0, err_code_o}, 32'h3);
    idle(CL + 1);
    chk("trcd_code_sticky", {29'b0, err_code_o}, 32'h3);

    // Back-to-back reads, PRE right behind them.
    for (int i = 0; i < 4; i++) wr(11'(i), 4'b0000, wd[i]);
    for (int i = 0; i < 4; i++) rd(11'(i), wd[i]);
    pre();
    idle(CL + 2);

    // tRP violation after a fresh reset; rejected ACT leaves the row closed.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst2_err", {31'b0, err_o}, 32'h0);
    act(11'h012);
    idle(4);
    pre();
    idle(3);
    act(11'h012);
    chk("trp_code", {29'b0, err_code_o}, 32'h4);
    rd_nopush(11'h034);
    act(11'h012);
    idle(4);
    rd(11'h034, 32'h5555BEAA);
    idle(CL + 1);
    chk("trp_code_sticky", {29'b0, err_code_o}, 32'h4);

    // Reset with a read two edges from completion.
    rd_nopush(11'h001);
    idle(3);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrd_q", DRAM_Q_o, 32'h0);
    chk("midrd_valid", {31'b0, DRAM_valid_o}, 32'h0);
    chk("midrd_err", {31'b0, err_o}, 32'h0);
    rst = 1'b0;
    act(11'h012);
    idle(4);
    rd(11'h034, 32'h5555BEAA);
    idle(CL + 3);

    chk("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
